// File: rtl/exec_sequencer.sv
// Execution sequencer: arbitrates edge-detected events against instruction issue
// and paces the CPU through RUN/HALT/STEP with a prescaled tick and a breakpoint.
//
// state  | meaning
// S_HALT | no instructions issued; events still granted
// S_RUN  | one instruction per tick; breakpoint active
// S_STEP | one instruction as soon as no event is pending, then back to HALT
module exec_sequencer #(
  parameter int unsigned           PRESCALE_W   = 24,
  parameter logic [PRESCALE_W-1:0] PRESCALE_MAX = 24'd12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       turbo,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  input  logic [7:0] ip,
  input  logic [3:0] evt_req,
  output logic [3:0] evt_grant,
  output logic       go,
  output logic [1:0] state,
  output logic       bp_hit,
  output logic       evt_ovf
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            pend_q, pend_d;
  logic [3:0]            req_all, grant_d;
  logic                  tick_pend_q, tick_pend_d;
  logic                  skip_q, skip_d;
  logic                  go_d, bp_set, bp_hit_d, evt_ovf_d;
  logic                  tick, bp_match, evt_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      presc_q     <= '0;
      pend_q      <= '0;
      tick_pend_q <= 1'b0;
      skip_q      <= 1'b0;
      go          <= 1'b0;
      evt_grant   <= '0;
      bp_hit      <= 1'b0;
      evt_ovf     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      tick_pend_q <= tick_pend_d;
      skip_q      <= skip_d;
      go          <= go_d;
      evt_grant   <= grant_d;
      bp_hit      <= bp_hit_d;
      evt_ovf     <= evt_ovf_d;
    end
  end

  assign state = state_q;

  always_comb begin
    req_all  = pend_q | evt_req;
    evt_busy = |req_all;
    // Isolate the lowest set bit: fixed priority, bit 0 first.
    grant_d  = req_all & (~req_all + 4'd1);
    pend_d   = req_all & ~grant_d;
    tick     = turbo | (presc_q == PRESCALE_MAX);
    bp_match = bp_en & (ip == bp_addr) & ~skip_q;

    state_d     = state_q;
    tick_pend_d = tick_pend_q;
    skip_d      = skip_q;
    go_d        = 1'b0;
    bp_set      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d     = S_HALT;
          tick_pend_d = 1'b0;
        end else if (tick | tick_pend_q) begin
          if (evt_busy) begin
            tick_pend_d = 1'b1;
          end else if (bp_match) begin
            state_d     = S_HALT;
            tick_pend_d = 1'b0;
            bp_set      = 1'b1;
          end else begin
            go_d        = 1'b1;
            tick_pend_d = 1'b0;
            skip_d      = 1'b0;
          end
        end
      end
      S_STEP: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!evt_busy) begin
          go_d    = 1'b1;
          skip_d  = 1'b0;
          state_d = S_HALT;
        end
      end
      default: begin
        tick_pend_d = 1'b0;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (step_req) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end else if (run_req) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
    endcase

    // Prescaler only advances while staying in RUN, so each RUN entry starts a full period.
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      presc_d = (presc_q == PRESCALE_MAX) ? '0 : presc_q + PRESCALE_W'(1);
    end else begin
      presc_d = '0;
    end

    bp_hit_d  = bp_set | (bp_hit & ~(run_req | step_req));
    evt_ovf_d = evt_ovf | (|(evt_req & pend_q));
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a behavioural model predicts every cycle's
// outputs, a negedge monitor compares; directed scenarios are followed by random traffic.
module tb_exec_sequencer;

  localparam int PMAX = 3;

  logic       clock;
  logic       reset;
  logic       turbo, run_req, halt_req, step_req, bp_en;
  logic [7:0] bp_addr, ip;
  logic [3:0] evt_req;
  logic [3:0] evt_grant;
  logic       go;
  logic [1:0] state;
  logic       bp_hit, evt_ovf;

  int checks = 0;
  int errors = 0;

  exec_sequencer #(.PRESCALE_W(24), .PRESCALE_MAX(24'd3)) dut (
    .clock(clock), .reset(reset), .turbo(turbo), .run_req(run_req),
    .halt_req(halt_req), .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .ip(ip), .evt_req(evt_req), .evt_grant(evt_grant), .go(go), .state(state),
    .bp_hit(bp_hit), .evt_ovf(evt_ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef enum {M_HALT, M_RUN, M_STEP} mmode_t;
  typedef struct packed {
    logic [3:0] grant;
    logic       go;
    logic [1:0] st;
    logic       bphit;
    logic       ovf;
  } obs_t;

  obs_t   exp_q[$];
  mmode_t m_mode;
  int     m_run_cyc;
  bit [3:0] m_pend;
  bit     m_tickp, m_skip, m_bphit, m_ovf;
  logic [7:0] ip_mask;

  function automatic void model_reset();
    m_mode = M_RUN; m_run_cyc = 0; m_pend = '0;
    m_tickp = 0; m_skip = 0; m_bphit = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(output obs_t o);
    bit [3:0] want;
    bit [3:0] g;
    bit       fire, ticked, brk;
    mmode_t   nxt;
    want   = m_pend | evt_req;
    g      = '0;
    fire   = 0;
    brk    = 0;
    nxt    = m_mode;
    ticked = turbo || ((m_run_cyc % (PMAX + 1)) == PMAX);
    for (int b = 0; b < 4; b++) if (g == 0 && want[b]) g[b] = 1'b1;
    if ((evt_req & m_pend) != 0) m_ovf = 1;
    m_pend = want & ~g;
    if (m_mode == M_RUN) begin
      if (halt_req) nxt = M_HALT;
      else if (ticked || m_tickp) begin
        if (want != 0) m_tickp = 1;
        else if (bp_en && ip == bp_addr && !m_skip) begin nxt = M_HALT; brk = 1; end
        else begin fire = 1; m_tickp = 0; end
      end
    end else if (m_mode == M_STEP) begin
      if (halt_req) nxt = M_HALT;
      else if (want == 0) begin fire = 1; nxt = M_HALT; end
    end else begin
      if (halt_req) nxt = M_HALT;
      else if (step_req) begin nxt = M_STEP; m_skip = 1; end
      else if (run_req) begin nxt = M_RUN; m_skip = 1; end
    end
    if (fire) m_skip = 0;
    if (nxt != M_RUN) m_tickp = 0;
    if (brk) m_bphit = 1;
    else if (run_req || step_req) m_bphit = 0;
    m_run_cyc = (m_mode == M_RUN && nxt == M_RUN) ? m_run_cyc + 1 : 0;
    m_mode = nxt;
    o.grant = g;
    o.go    = fire;
    o.st    = (nxt == M_HALT) ? 2'b00 : (nxt == M_RUN) ? 2'b01 : 2'b10;
    o.bphit = m_bphit;
    o.ovf   = m_ovf;
  endfunction

  always @(negedge clock) begin
    obs_t e, a;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {evt_grant, go, state, bp_hit, evt_ovf};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got grant=%b go=%b state=%b bp_hit=%b ovf=%b expected grant=%b go=%b state=%b bp_hit=%b ovf=%b",
                 $time, a.grant, a.go, a.st, a.bphit, a.ovf, e.grant, e.go, e.st, e.bphit, e.ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic cycle();
    obs_t e;
    @(posedge clock);
    model_edge(e);
    exp_q.push_back(e);
    #1;
    if (e.go) ip = (ip + 8'd1) & ip_mask;
    run_req = 0; halt_req = 0; step_req = 0; evt_req = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_go", go, 0);
    chk("rst_grant", evt_grant, 0);
    chk("rst_state", state, 2'b01);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_ovf", evt_ovf, 0);
    exp_q.delete();
    model_reset();
    run_req = 0; halt_req = 0; step_req = 0; evt_req = '0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    bit hit;
    int g2;
    reset = 1'b1; turbo = 0; run_req = 0; halt_req = 0; step_req = 0;
    bp_en = 0; bp_addr = 8'h05; ip = 8'h00; evt_req = '0; ip_mask = 8'hff;
    model_reset();
    #1 reset = 1'b0;
    #2;
    chk("init_state", state, 2'b01);
    chk("init_go", go, 0);
    chk("init_grant", evt_grant, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Prescaled run: go on every fourth edge
    for (int i = 1; i <= 12; i++) begin
      cycle();
      chk("prescale_go", go, (i % 4 == 0) ? 1 : 0);
      chk("prescale_grant", evt_grant, 0);
    end

    // Turbo with two simultaneous events
    turbo = 1;
    cycle();
    evt_req = 4'b0101;
    cycle(); chk("evt_g0", evt_grant, 4'b0001); chk("evt_g0_go", go, 0);
    cycle(); chk("evt_g2", evt_grant, 4'b0100); chk("evt_g2_go", go, 0);
    cycle(); chk("evt_then_go", go, 1);     chk("evt_then_grant", evt_grant, 0);

    // Breakpoint at 05, then resume executes it once
    bp_en = 1; bp_addr = 8'h05; ip = 8'h02; hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      cycle();
      if (state == 2'b00) hit = 1;
    end
    chk("bp_halted", hit, 1);
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_go_withheld", go, 0);
    run_req = 1;
    cycle(); chk("bp_resume_state", state, 2'b01); chk("bp_hit_clr", bp_hit, 0);
    cycle(); chk("bp_resume_go", go, 1);
    cycle(); chk("bp_continue_go", go, 1); chk("bp_continue_state", state, 2'b01);

    // Step with a coincident event
    bp_en = 0; halt_req = 1;
    cycle(); chk("halt_state", state, 2'b00);
    step_req = 1; evt_req = 4'b0010;
    cycle(); chk("step_grant", evt_grant, 4'b0010); chk("step_nogo", go, 0); chk("step_state", state, 2'b10);
    cycle(); chk("step_go", go, 1); chk("step_back_halt", state, 2'b00);
    cycle(); chk("step_single", go, 0);

    // Simultaneous requests and overflow
    run_req = 1;
    cycle(); chk("rerun_state", state, 2'b01);
    halt_req = 1; step_req = 1; run_req = 1;
    cycle(); chk("prio_state", state, 2'b00); chk("prio_nogo", go, 0);
    g2 = 0;
    evt_req = 4'b0101;
    cycle(); chk("ovf_g0", evt_grant, 4'b0001); if (evt_grant[2]) g2++;
    evt_req = 4'b0100;
    cycle(); chk("ovf_flag", evt_ovf, 1); if (evt_grant[2]) g2++;
    cycle(); chk("ovf_sticky", evt_ovf, 1); if (evt_grant[2]) g2++;
    chk("ovf_single_grant", g2, 1);

    // Reset with events and a tick still pending
    run_req = 1;
    cycle(); chk("pre_rst_state", state, 2'b01);
    evt_req = 4'b1011;
    cycle(); chk("pre_rst_grant", evt_grant, 4'b0001);
    do_reset();
    turbo = 0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("post_rst_grant", evt_grant, 0);
      chk("post_rst_go", go, 0);
    end

    // Random traffic against the model
    ip_mask = 8'h0f; ip = ip & ip_mask;
    for (int n = 0; n < 3000; n++) begin
      evt_req = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      run_req  = ($urandom_range(0, 19) == 0);
      halt_req = ($urandom_range(0, 29) == 0);
      step_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) turbo = ~turbo;
      if ($urandom_range(0, 39) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 99) == 0) bp_addr = 8'($urandom_range(0, 15));
      cycle();
      if (n == 1500) do_reset();
    end

    @(negedge clock);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
